// File: rtl/prince_rand_pkg.sv
// Shared constants, zero-seed fix values and FSM encoding for the PRINCE
// fresh-randomness source.
package prince_rand_pkg;

  localparam int N_LANE = 4;
  localparam int LANE_W = 47;
  localparam int RAND_W = N_LANE * LANE_W;

  // Feedback taps of x^47 + x^5 + 1 in the left-shifting lane register
  localparam int TAP_HI = 46;
  localparam int TAP_LO = 4;

  localparam logic [LANE_W-1:0] LANE_0_FIX = 47'h1;
  localparam logic [LANE_W-1:0] LANE_1_FIX = 47'h2;
  localparam logic [LANE_W-1:0] LANE_2_FIX = 47'h3;
  localparam logic [LANE_W-1:0] LANE_3_FIX = 47'h4;

  typedef enum logic [1:0] {
    UNSEEDED  = 2'd0,
    WARMUP    = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } state_e;

  function automatic logic [LANE_W-1:0] lane_fix(input logic [1:0] k);
    case (k)
      2'd0:    return LANE_0_FIX;
      2'd1:    return LANE_1_FIX;
      2'd2:    return LANE_2_FIX;
      default: return LANE_3_FIX;
    endcase
  endfunction

endpackage

// File: rtl/prince_rand_source_lfsr47_adv47.sv
// One lane of the randomness source: 47 Fibonacci LFSR steps unrolled into a
// single combinational advance, so a lane never reuses a delivered bit.
module lfsr47_adv47
  import prince_rand_pkg::*;
(
  input  logic [LANE_W-1:0] lane_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [LANE_W-1:0] work;

  always_comb begin
    work = lane_i;
    for (int i = 0; i < LANE_W; i++) begin
      work = {work[LANE_W-2:0], work[TAP_HI] ^ work[TAP_LO]};
    end
    lane_o = work;
  end

endmodule

// File: rtl/prince_rand_source.sv
// Producer of the 188-bit fresh-randomness word for the masked PRINCE datapath.
// Optional lane-0 repeat / zero-lane health monitor: define PRINCE_RAND_HEALTH_EN.
module prince_rand_source
  import prince_rand_pkg::*;
#(
  parameter int unsigned WARMUP_CYC   = 8,
  parameter int unsigned RESEED_LIMIT = 1048576,
  parameter int unsigned CNT_W        = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAND_W-1:0] seed_i,
  input  logic              seed_load_i,
  output logic [RAND_W-1:0] rnd_o,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic              reseed_req_o,
  output logic              busy_o
`ifdef PRINCE_RAND_HEALTH_EN
  ,
  output logic              health_err_o
`endif
);

  localparam int unsigned WCNT_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(RESEED_LIMIT);

  state_e              state_q, state_d;
  logic [RAND_W-1:0]   lanes_q, lanes_d;
  logic [RAND_W-1:0]   lanes_adv;
  logic [RAND_W-1:0]   seed_fix;
  logic [WCNT_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                handshake;
  logic                health_block;

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    lfsr47_adv47 u_adv (
      .lane_i (lanes_q[k*LANE_W +: LANE_W]),
      .lane_o (lanes_adv[k*LANE_W +: LANE_W])
    );

    // An all-zero slice would lock the LFSR, so it is replaced by a fixed value
    assign seed_fix[k*LANE_W +: LANE_W] =
      (seed_i[k*LANE_W +: LANE_W] == '0) ? lane_fix(2'(k))
                                         : seed_i[k*LANE_W +: LANE_W];
  end

  assign rnd_valid_o  = (state_q == RUN) && !health_block;
  assign handshake    = rnd_valid_o && rnd_ready_i;
  assign rnd_o        = lanes_q;
  assign reseed_req_o = (state_q == EXHAUSTED);
  assign busy_o       = (state_q == WARMUP);

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    warm_cnt_d = warm_cnt_q;
    word_cnt_d = word_cnt_q;
    // A seed load wins over a coincident handshake; that word is dropped
    if (seed_load_i) begin
      lanes_d    = seed_fix;
      warm_cnt_d = '0;
      word_cnt_d = '0;
      state_d    = WARMUP;
    end else begin
      case (state_q)
        WARMUP: begin
          lanes_d    = lanes_adv;
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_d = '0;
            word_cnt_d = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            lanes_d    = lanes_adv;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_d == CNT_LIMIT) begin
              state_d = EXHAUSTED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNSEEDED;
      lanes_q    <= '0;
      warm_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      warm_cnt_q <= warm_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef PRINCE_RAND_HEALTH_EN
  logic [LANE_W-1:0] last_lane0_q, last_lane0_d;
  logic              have_last_q, have_last_d;
  logic              health_err_q, health_err_d;
  logic              lane_zero;

  always_comb begin
    lane_zero = 1'b0;
    for (int k = 0; k < N_LANE; k++) begin
      if (lanes_q[k*LANE_W +: LANE_W] == '0) begin
        lane_zero = 1'b1;
      end
    end
    lane_zero = lane_zero && (state_q != UNSEEDED);
  end

  always_comb begin
    last_lane0_d = last_lane0_q;
    have_last_d  = have_last_q;
    health_err_d = health_err_q;
    if (seed_load_i) begin
      last_lane0_d = '0;
      have_last_d  = 1'b0;
      health_err_d = 1'b0;
    end else begin
      if (handshake) begin
        if (have_last_q && (lanes_q[LANE_W-1:0] == last_lane0_q)) begin
          health_err_d = 1'b1;
        end
        last_lane0_d = lanes_q[LANE_W-1:0];
        have_last_d  = 1'b1;
      end
      if (lane_zero) begin
        health_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lane0_q <= '0;
      have_last_q  <= 1'b0;
      health_err_q <= 1'b0;
    end else begin
      last_lane0_q <= last_lane0_d;
      have_last_q  <= have_last_d;
      health_err_q <= health_err_d;
    end
  end

  assign health_block = health_err_q;
  assign health_err_o = health_err_q;
`else
  assign health_block = 1'b0;
`endif

endmodule

// File: tb/tb_prince_rand_source.sv
// Self-checking bench for prince_rand_source: bit-stream reference model,
// table-driven seed/ready vectors, directed corner cases and random traffic.
module tb_prince_rand_source;

  localparam int LW    = 47;
  localparam int NL    = 4;
  localparam int RW    = 188;
  localparam int WARM  = 8;
  localparam int LIMIT = 4;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;
  localparam int M_EXH  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] seed_i;
  logic          seed_load_i;
  logic [RW-1:0] rnd_o;
  logic          rnd_valid_o;
  logic          rnd_ready_i;
  logic          reseed_req_o;
  logic          busy_o;
`ifdef PRINCE_RAND_HEALTH_EN
  logic          health_err_o;
`endif

  prince_rand_source #(
    .WARMUP_CYC   (WARM),
    .RESEED_LIMIT (LIMIT),
    .CNT_W        (21)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_i       (seed_i),
    .seed_load_i  (seed_load_i),
    .rnd_o        (rnd_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .reseed_req_o (reseed_req_o),
    .busy_o       (busy_o)
`ifdef PRINCE_RAND_HEALTH_EN
    ,
    .health_err_o (health_err_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: lane word, coarse mode, remaining warm-up, delivered count
  logic [RW-1:0] m_lanes;
  int            m_mode;
  int            m_warm_left;
  int            m_delivered;

  int            n_checks;
  int            n_fail;
  int            n_accept;
  logic [RW-1:0] acc_q[$];

  typedef struct {
    logic [RW-1:0] seed;
    logic [15:0]   ready_pat;
    int            exp_words;
  } vec_t;

  vec_t vecs[5];

  // A lane is a window of 47 consecutive bits of the sequence b[n+47] = b[n] ^ b[n+42];
  // bit 46 of the register holds the oldest bit. One advance slides the window by 47.
  function automatic logic [LW-1:0] lane_adv(input logic [LW-1:0] s);
    bit b[94];
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++) b[i] = s[LW-1-i];
    for (int n = 0; n < LW; n++) b[n+LW] = b[n] ^ b[n+42];
    for (int i = 0; i < LW; i++) r[LW-1-i] = b[LW+i];
    return r;
  endfunction

  function automatic logic [RW-1:0] word_adv(input logic [RW-1:0] w);
    logic [RW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*LW +: LW] = lane_adv(w[k*LW +: LW]);
    return r;
  endfunction

  function automatic logic [RW-1:0] fix_seed(input logic [RW-1:0] s);
    logic [RW-1:0] r;
    for (int k = 0; k < NL; k++) begin
      r[k*LW +: LW] = (s[k*LW +: LW] == '0) ? LW'(k + 1) : s[k*LW +: LW];
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_word();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[RW-1:0];
  endfunction

  task automatic model_reset();
    m_lanes     = '0;
    m_mode      = M_IDLE;
    m_warm_left = 0;
    m_delivered = 0;
  endtask

  task automatic compareField(input string name, input logic [RW-1:0] act,
                              input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    compareField("rnd_o", rnd_o, m_lanes);
    compareField("rnd_valid_o", RW'(rnd_valid_o), RW'(m_mode == M_RUN));
    compareField("busy_o", RW'(busy_o), RW'(m_mode == M_WARM));
    compareField("reseed_req_o", RW'(reseed_req_o), RW'(m_mode == M_EXH));
  endtask

  task automatic applyStimulus(input logic load, input logic [RW-1:0] seed,
                               input logic ready);
    seed_i      = seed;
    seed_load_i = load;
    rnd_ready_i = ready;
    if (rnd_valid_o && ready && !load) begin
      n_accept++;
      acc_q.push_back(rnd_o);
    end
    @(posedge clk);
    if (load) begin
      m_lanes     = fix_seed(seed);
      m_mode      = M_WARM;
      m_warm_left = WARM;
      m_delivered = 0;
    end else if (m_mode == M_WARM) begin
      m_lanes = word_adv(m_lanes);
      m_warm_left--;
      if (m_warm_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN && ready) begin
      m_lanes = word_adv(m_lanes);
      m_delivered++;
      if (m_delivered == LIMIT) m_mode = M_EXH;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    logic [RW-1:0] g;
    logic [RW-1:0] w1;
    logic [RW-1:0] s;

    n_checks = 0;
    n_fail   = 0;
    n_accept = 0;
    rst_n       = 1'b0;
    seed_load_i = 1'b0;
    rnd_ready_i = 1'b0;
    seed_i      = '0;
    model_reset();

    vecs[0] = '{seed: '0, ready_pat: 16'hFFFF, exp_words: 4};
    vecs[1] = '{seed: 188'h1, ready_pat: 16'h0000, exp_words: 0};
    vecs[2] = '{seed: {47'h1234567, 47'd0, 47'h7FFF_FFFF_FFFF, 47'h5},
                ready_pat: 16'hAAAA, exp_words: 4};
    vecs[3] = '{seed: '1, ready_pat: 16'h0101, exp_words: 2};
    vecs[4] = '{seed: {4{47'h0ABC_DEF0_1234}}, ready_pat: 16'h0007, exp_words: 3};

    #2 checkOutput();
    #10 rst_n = 1'b1;

    $display("[TB] unseeded idle");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, rand_word(), 1'b1);

    $display("[TB] zero seed load and warm-up");
    applyStimulus(1'b1, '0, 1'b0);
    compareField("zero_seed_fix", rnd_o, {47'd4, 47'd3, 47'd2, 47'd1});
    for (int i = 0; i < WARM; i++) applyStimulus(1'b0, '0, 1'b1);
    g = {47'd4, 47'd3, 47'd2, 47'd1};
    for (int i = 0; i < WARM; i++) g = word_adv(g);
    compareField("first_word", rnd_o, g);

    $display("[TB] ready toggling 1,0,0,1");
    applyStimulus(1'b1, 188'h1, 1'b0);
    for (int i = 0; i < WARM; i++) applyStimulus(1'b0, '0, 1'b0);
    n_accept = 0;
    acc_q.delete();
    applyStimulus(1'b0, '0, 1'b1);
    w1 = rnd_o;
    applyStimulus(1'b0, '0, 1'b0);
    compareField("stable_ready_low", rnd_o, w1);
    applyStimulus(1'b0, '0, 1'b0);
    compareField("stable_ready_low2", rnd_o, w1);
    applyStimulus(1'b0, '0, 1'b1);
    compareField("accept_count", RW'(n_accept), RW'(2));
    g = fix_seed(188'h1);
    for (int i = 0; i < WARM; i++) g = word_adv(g);
    if (acc_q.size() == 2) begin
      compareField("accepted_word0", acc_q[0], g);
      compareField("accepted_word1", acc_q[1], word_adv(g));
    end

    $display("[TB] reseed limit exhaustion");
    applyStimulus(1'b1, rand_word(), 1'b1);
    for (int i = 0; i < WARM + LIMIT + 3; i++) applyStimulus(1'b0, '0, 1'b1);
    compareField("exhausted_req", RW'(reseed_req_o), RW'(1));
    applyStimulus(1'b1, rand_word(), 1'b1);
    compareField("reseed_cleared", RW'(reseed_req_o), RW'(0));

    $display("[TB] seed load coincident with handshake");
    for (int i = 0; i < WARM + 1; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, rand_word(), 1'b1);
    for (int i = 0; i < WARM + LIMIT + 2; i++) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] asynchronous reset mid warm-up");
    applyStimulus(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    checkOutput();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, rand_word(), 1'b1);

    $display("[TB] table-driven vectors");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, vecs[v].seed, 1'b0);
      for (int i = 0; i < WARM; i++) applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)));
      n_accept = 0;
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, vecs[v].ready_pat[i]);
      compareField($sformatf("vec%0d_words", v), RW'(n_accept), RW'(vecs[v].exp_words));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      s = rand_word();
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 3)*LW +: LW] = '0;
      applyStimulus(1'($urandom_range(0, 29) == 0), s, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prince_rand_source.md
Name: prince_rand_source

Overview:
- Producer end of the 188-bit fresh-randomness bus consumed by the masked 6-stage PRINCE datapath; its output feeds the randomness shuffler, which derives the four rotated copies.
- Four independent 47-bit Fibonacci LFSR lanes (4 x 47 = 188). Each lane advances 47 steps per accepted word, so lanes never reuse bits.
- Valid/ready handshake toward the cipher.
- Seed loading, warm-up, reseed-limit exhaustion, and a sticky reseed request.

Parameters:
- RAND_W, 188, width of the randomness word; must equal N_LANE*LANE_W.
- N_LANE, 4, number of LFSR lanes.
- LANE_W, 47, lane width; feedback polynomial x^47 + x^5 + 1.
- WARMUP_CYC, 8, lane advances after a seed load before the first valid word.
- RESEED_LIMIT, 1048576, words delivered per seed before output stops.
- CNT_W, 21, delivered-word counter width; must satisfy 2^CNT_W > RESEED_LIMIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_i  in  188  seed value; lane k = seed_i[47k+46:47k].
- seed_load_i  in  1  one-cycle pulse; loads seed_i.
- rnd_o  out  188  randomness word; equals the lane state register.
- rnd_valid_o  out  1  rnd_o holds a fresh, never-delivered word.
- rnd_ready_i  in  1  consumer accepts rnd_o this cycle.
- reseed_req_o  out  1  sticky; RESEED_LIMIT words delivered, new seed required.
- busy_o  out  1  high in WARMUP.

Behaviour:
- Reset (async, rst_n low): state=UNSEEDED; lanes=0; rnd_o=0; rnd_valid_o=0; reseed_req_o=0; busy_o=0; counters=0.
- Lane step, per lane, s[46:0]: new_bit = s[46]^s[4]; s <= {s[45:0], new_bit}. One "advance" = 47 consecutive steps, computed combinationally in one cycle.
- Zero-seed guard: a lane seed slice of all-zero loads the constant LANE_k_FIX = 47'h1 + k instead. No lane ever holds zero.
- FSM states:
  - UNSEEDED: rnd_valid_o=0. seed_load_i -> WARMUP.
  - WARMUP: advance every cycle; warm-up counter counts 0..WARMUP_CYC-1; busy_o=1. After the last advance -> RUN, with word_cnt=0.
  - RUN: rnd_valid_o=1. On rnd_valid_o&&rnd_ready_i: advance and increment word_cnt. When the incremented value equals RESEED_LIMIT -> EXHAUSTED, in the same edge.
  - EXHAUSTED: rnd_valid_o=0; reseed_req_o=1; lanes hold.
- seed_load_i from any state: reload lanes, clear word_cnt and the warm-up counter, clear reseed_req_o, enter WARMUP next cycle.
  - Priority over a simultaneous handshake: that word counts as NOT delivered, and the consumer must treat it as dropped.
- Latency: seed_load_i at cycle t -> rnd_valid_o high at t+1+WARMUP_CYC.
- Valid/ready rules:
  - rnd_o is stable while rnd_valid_o=1 and rnd_ready_i=0.
  - rnd_valid_o does not depend combinationally on rnd_ready_i.
  - Back-to-back acceptance delivers one new word per cycle.
- rnd_ready_i is ignored outside RUN.
- Reset mid-warm-up or mid-RUN returns to UNSEEDED; no state is retained.

Optional Feature:
- Macro: PRINCE_RAND_HEALTH_EN.
- When defined:
  - Add output health_err_o (1 bit, reset 0).
  - Registers a copy of the last delivered lane 0.
  - Sets health_err_o sticky when the next delivered lane 0 equals it, or when any lane state is zero.
  - While health_err_o=1, rnd_valid_o is forced 0.
  - Cleared only by seed_load_i or reset.
- When undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package prince_rand_pkg holds:
  - RAND_W, LANE_W, N_LANE.
  - Tap positions 46 and 4.
  - LANE_k_FIX constants.
  - FSM state encoding: UNSEEDED=2'd0, WARMUP=2'd1, RUN=2'd2, EXHAUSTED=2'd3.
- Sub-module lfsr47_adv47: purely combinational 47-step advance of one lane, instantiated N_LANE times.
- The top-level module holds the FSM, counters and handshake.

Test Plan:
1. Reset, then no seed for 20 cycles -> rnd_valid_o=0, rnd_o=0, reseed_req_o=0 throughout.
2. seed_i = all-zero, seed_load_i at t -> lanes load 1,2,3,4. busy_o=1 for cycles t+1..t+8. rnd_valid_o rises at t+9 with rnd_o equal to the golden model's 8 advances of {4,3,2,1}.
3. Seed 188'h1, rnd_ready_i toggling 1,0,0,1 in RUN -> rnd_o unchanged during the ready-low cycles; exactly two distinct words accepted, matching the model sequence.
4. RESEED_LIMIT overridden to 4, ready held high -> 4 words accepted, then rnd_valid_o=0 and reseed_req_o=1. A new seed_load_i clears reseed_req_o the next cycle and restarts warm-up.
5. seed_load_i coincident with a RUN handshake -> word_cnt=0, state WARMUP next cycle; the model does not count that word.
6. rst_n pulled low asynchronously mid-WARMUP (between clock edges) -> outputs go to reset values immediately; state UNSEEDED after release.
